// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BTB query, next-PC prediction, mispredict redirect with epoch flush, BTB update.
// Latency: prediction captured in the same cycle as the BTB lookup; redirect refetches two cycles after EX resolution.
// Backpressure: output register holds while fetch_valid && !fetch_ready; pc_q does not advance during a stall.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   btb_pc_query / btb_hit / btb_target     combinational BTB lookup of pc_q
//   btb_update_en / btb_pc_update / btb_target_update   registered one-cycle BTB write
//   fetch_valid / fetch_ready / fetch_pc / fetch_pred_taken / fetch_pred_target / fetch_epoch
//                                    valid/ready output register to IF/ID
//   ex_valid / ex_pc / ex_target / ex_taken / ex_pred_target / ex_epoch
//                                    branch resolution from EX
//   mispredict_cnt                   saturating count of accepted mispredicts
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [31:0]         btb_pc_query,
    input  logic                btb_hit,
    input  logic [31:0]         btb_target,
    output logic                btb_update_en,
    output logic [31:0]         btb_pc_update,
    output logic [31:0]         btb_target_update,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic [31:0]         fetch_pc,
    output logic                fetch_pred_taken,
    output logic [31:0]         fetch_pred_target,
    output logic                fetch_epoch,
    input  logic                ex_valid,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_target,
    input  logic                ex_taken,
    input  logic [31:0]         ex_pred_target,
    input  logic                ex_epoch,
    output logic [CNT_BITS-1:0] mispredict_cnt
);

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        epoch;
    } fetch_t;

    logic [31:0] pc_q;
    logic        epoch_q;
    fetch_t      out_q;

    logic [31:0] seq;
    logic        pred_taken;
    logic [31:0] pred_next;
    logic        live;
    logic [31:0] actual_next;
    logic        mispredict;
    logic        load;

    always_comb begin
        seq         = pc_q + 32'd4;
        // A hit whose target is the fall-through is not a taken prediction;
        // this is how a not-taken BTB rewrite suppresses the branch.
        pred_taken  = btb_hit && (btb_target != seq);
        pred_next   = btb_hit ? btb_target : seq;
        // Resolutions tagged with the previous epoch belong to flushed wrong-path fetches.
        live        = ex_valid && (ex_epoch == epoch_q);
        actual_next = ex_taken ? ex_target : (ex_pc + 32'd4);
        mispredict  = live && (actual_next != ex_pred_target);
        load        = !out_q.vld || fetch_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q              <= RESET_PC;
            epoch_q           <= 1'b0;
            out_q             <= '0;
            btb_update_en     <= 1'b0;
            btb_pc_update     <= '0;
            btb_target_update <= '0;
            mispredict_cnt    <= '0;
        end else begin
            btb_update_en <= mispredict;
            if (mispredict) begin
                // Redirect wins over any accept this cycle: the held fetch is wrong-path.
                pc_q              <= actual_next;
                out_q.vld         <= 1'b0;
                epoch_q           <= ~epoch_q;
                btb_pc_update     <= ex_pc;
                btb_target_update <= actual_next;
                if (mispredict_cnt != '1) begin
                    mispredict_cnt <= mispredict_cnt + CNT_BITS'(1);
                end
            end else if (load) begin
                out_q <= '{vld: 1'b1, pc: pc_q, taken: pred_taken,
                           target: pred_next, epoch: epoch_q};
                pc_q  <= pred_next;
            end
        end
    end

    assign btb_pc_query      = pc_q;
    assign fetch_valid       = out_q.vld;
    assign fetch_pc          = out_q.pc;
    assign fetch_pred_taken  = out_q.taken;
    assign fetch_pred_target = out_q.target;
    assign fetch_epoch       = out_q.epoch;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

    localparam int CNT_BITS = 4;
    localparam int CNT_MAX  = 15;

    logic                clk;
    logic                rst_n;
    logic [31:0]         btb_pc_query;
    logic                btb_hit;
    logic [31:0]         btb_target;
    logic                btb_update_en;
    logic [31:0]         btb_pc_update;
    logic [31:0]         btb_target_update;
    logic                fetch_valid;
    logic                fetch_ready;
    logic [31:0]         fetch_pc;
    logic                fetch_pred_taken;
    logic [31:0]         fetch_pred_target;
    logic                fetch_epoch;
    logic                ex_valid;
    logic [31:0]         ex_pc;
    logic [31:0]         ex_target;
    logic                ex_taken;
    logic [31:0]         ex_pred_target;
    logic                ex_epoch;
    logic [CNT_BITS-1:0] mispredict_cnt;

    fetch_pc_gen #(.RESET_PC(32'h8000_0000), .CNT_BITS(CNT_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .btb_pc_query(btb_pc_query), .btb_hit(btb_hit), .btb_target(btb_target),
        .btb_update_en(btb_update_en), .btb_pc_update(btb_pc_update),
        .btb_target_update(btb_target_update),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
        .fetch_epoch(fetch_epoch),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
        .ex_pred_target(ex_pred_target), .ex_epoch(ex_epoch),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the fetch stream must look like.
    logic [31:0] m_pc;
    logic        m_epoch;
    logic        m_vld;
    logic [31:0] m_fpc;
    logic        m_ftk;
    logic [31:0] m_ftgt;
    logic        m_fep;
    logic        m_upd_en;
    logic [31:0] m_upd_pc;
    logic [31:0] m_upd_tgt;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_epoch = 1'b0; m_vld = 1'b0;
        m_fpc = '0; m_ftk = 1'b0; m_ftgt = '0; m_fep = 1'b0;
        m_upd_en = 1'b0; m_upd_pc = '0; m_upd_tgt = '0; m_cnt = 0;
    endtask

    // One clock of the fetch rules, evaluated on the inputs held across the edge.
    task automatic model_step();
        logic [31:0] fall, nxt, actual;
        logic        wrong;
        fall   = m_pc + 32'd4;
        nxt    = btb_hit ? btb_target : fall;
        actual = ex_taken ? ex_target : ex_pc + 32'd4;
        wrong  = ex_valid && (ex_epoch == m_epoch) && (actual != ex_pred_target);
        m_upd_en = wrong;
        if (wrong) begin
            m_upd_pc  = ex_pc;
            m_upd_tgt = actual;
            m_cnt     = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_pc      = actual;
            m_vld     = 1'b0;
            m_epoch   = ~m_epoch;
        end else if (!m_vld || fetch_ready) begin
            m_vld  = 1'b1;
            m_fpc  = m_pc;
            m_ftk  = btb_hit && (btb_target != fall);
            m_ftgt = nxt;
            m_fep  = m_epoch;
            m_pc   = nxt;
        end
    endtask

    // Compare process: checks every output against the reference each cycle.
    always @(negedge clk) begin
        chk("valid", {31'd0, fetch_valid}, {31'd0, m_vld});
        chk("query", btb_pc_query, m_pc);
        chk("upd_en", {31'd0, btb_update_en}, {31'd0, m_upd_en});
        chk("upd_pc", btb_pc_update, m_upd_pc);
        chk("upd_tgt", btb_target_update, m_upd_tgt);
        chk("cnt", {28'd0, mispredict_cnt}, m_cnt);
        if (m_vld) begin
            chk("fpc", fetch_pc, m_fpc);
            chk("ftk", {31'd0, fetch_pred_taken}, {31'd0, m_ftk});
            chk("ftgt", fetch_pred_target, m_ftgt);
            chk("fep", {31'd0, fetch_epoch}, {31'd0, m_fep});
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic ex_clear();
        ex_valid = 1'b0; ex_pc = '0; ex_target = '0; ex_taken = 1'b0;
        ex_pred_target = '0; ex_epoch = 1'b0;
    endtask

    task automatic ex_drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic [31:0] pred, input logic ep);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
        ex_pred_target = pred; ex_epoch = ep;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_fpc"}, fetch_pc, 32'd0);
        chk({tag, "_ftk"}, {31'd0, fetch_pred_taken}, 32'd0);
        chk({tag, "_ftgt"}, fetch_pred_target, 32'd0);
        chk({tag, "_fep"}, {31'd0, fetch_epoch}, 32'd0);
        chk({tag, "_query"}, btb_pc_query, 32'h8000_0000);
        chk({tag, "_upd_en"}, {31'd0, btb_update_en}, 32'd0);
        chk({tag, "_upd_pc"}, btb_pc_update, 32'd0);
        chk({tag, "_upd_tgt"}, btb_target_update, 32'd0);
        chk({tag, "_cnt"}, {28'd0, mispredict_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; btb_hit = 1'b0; btb_target = '0; fetch_ready = 1'b1;
        ex_clear();
        model_reset();
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Sequential stream from RESET_PC.
        cyc();
        chk("s0_valid", {31'd0, fetch_valid}, 32'd1);
        chk("s0_pc", fetch_pc, 32'h8000_0000);
        chk("s0_tk", {31'd0, fetch_pred_taken}, 32'd0);
        cyc();
        chk("s1_pc", fetch_pc, 32'h8000_0004);
        btb_hit = 1'b1; btb_target = 32'h8000_0100;
        cyc();
        chk("hit_pc", fetch_pc, 32'h8000_0008);
        chk("hit_tk", {31'd0, fetch_pred_taken}, 32'd1);
        chk("hit_tgt", fetch_pred_target, 32'h8000_0100);
        btb_hit = 1'b0;
        cyc();
        chk("jump_pc", fetch_pc, 32'h8000_0100);

        // Three-cycle stall.
        fetch_ready = 1'b0;
        repeat (3) cyc();
        chk("stall_pc", fetch_pc, 32'h8000_0100);
        chk("stall_query", btb_pc_query, 32'h8000_0104);
        fetch_ready = 1'b1;
        cyc();
        chk("resume_pc", fetch_pc, 32'h8000_0104);

        // Taken mispredict.
        ex_drive(32'h8000_0010, 1'b1, 32'h8000_0200, 32'h8000_0014, 1'b0);
        cyc();
        ex_clear();
        chk("mp_valid", {31'd0, fetch_valid}, 32'd0);
        chk("mp_upd_en", {31'd0, btb_update_en}, 32'd1);
        chk("mp_upd_pc", btb_pc_update, 32'h8000_0010);
        chk("mp_upd_tgt", btb_target_update, 32'h8000_0200);
        chk("mp_cnt", {28'd0, mispredict_cnt}, 32'd1);
        cyc();
        chk("redir_pc", fetch_pc, 32'h8000_0200);
        chk("redir_ep", {31'd0, fetch_epoch}, 32'd1);
        chk("redir_upd_en", {31'd0, btb_update_en}, 32'd0);

        // Stale epoch with a wrong target is ignored.
        ex_drive(32'h8000_0030, 1'b1, 32'h8000_0400, 32'h8000_0034, 1'b0);
        cyc();
        chk("stale_upd_en", {31'd0, btb_update_en}, 32'd0);
        chk("stale_cnt", {28'd0, mispredict_cnt}, 32'd1);
        chk("stale_pc", fetch_pc, 32'h8000_0204);

        // Not-taken mispredict, then a back-to-back resolution carrying the old epoch.
        ex_drive(32'h8000_0020, 1'b0, 32'h8000_0100, 32'h8000_0100, 1'b1);
        cyc();
        chk("nt_upd_pc", btb_pc_update, 32'h8000_0020);
        chk("nt_upd_tgt", btb_target_update, 32'h8000_0024);
        chk("nt_cnt", {28'd0, mispredict_cnt}, 32'd2);
        cyc();
        ex_clear();
        chk("b2b_cnt", {28'd0, mispredict_cnt}, 32'd2);
        chk("b2b_pc", fetch_pc, 32'h8000_0024);
        chk("b2b_ep", {31'd0, fetch_epoch}, 32'd0);

        // Wrap from 0xFFFFFFFC.
        ex_drive(32'h8000_0024, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        cyc();
        ex_clear();
        cyc();
        chk("wrap0_pc", fetch_pc, 32'hFFFF_FFFC);
        cyc();
        chk("wrap1_pc", fetch_pc, 32'h0000_0000);
        // Hit whose target is the fall-through is not a taken prediction.
        btb_hit = 1'b1; btb_target = 32'h0000_0008;
        cyc();
        btb_hit = 1'b0;
        chk("ft_pc", fetch_pc, 32'h0000_0004);
        chk("ft_tk", {31'd0, fetch_pred_taken}, 32'd0);
        chk("ft_tgt", fetch_pred_target, 32'h0000_0008);

        // Drive the counter past its ceiling.
        for (int i = 0; i < 14; i++) begin
            ex_drive(32'h9000_0000 + 32'(i * 16), 1'b1, 32'hA000_0000 + 32'(i * 16),
                     32'hA000_0008 + 32'(i * 16), m_epoch);
            cyc();
            ex_clear();
            cyc();
        end
        chk("sat_cnt", {28'd0, mispredict_cnt}, 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            fetch_ready = ($urandom_range(0, 3) != 0);
            btb_hit     = ($urandom_range(0, 9) < 3);
            btb_target  = ($urandom_range(0, 3) == 0) ? m_pc + 32'd4 : ($urandom() & 32'hFFFF_FFFC);
            if ($urandom_range(0, 4) == 0) begin
                ex_valid = 1'b1;
                ex_pc    = $urandom() & 32'hFFFF_FFFC;
                ex_taken = $urandom_range(0, 1) == 1;
                ex_target = $urandom() & 32'hFFFF_FFFC;
                ex_epoch = ($urandom_range(0, 4) == 0) ? ~m_epoch : m_epoch;
                a = ex_taken ? ex_target : ex_pc + 32'd4;
                ex_pred_target = ($urandom_range(0, 1) == 1) ? a : ($urandom() & 32'hFFFF_FFFC);
            end else begin
                ex_clear();
            end
            cyc();
        end
        ex_clear(); btb_hit = 1'b0; fetch_ready = 1'b1;
        cyc();

        // Reset asserted in the middle of a stall.
        fetch_ready = 1'b0;
        cyc(); cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        fetch_ready = 1'b1;
        cyc();
        chk("post_rst_pc", fetch_pc, 32'h8000_0000);
        chk("post_rst_valid", {31'd0, fetch_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Instruction-fetch PC generator that sits directly upstream of the branch target buffer. It drives the BTB query PC each cycle and turns hit/target into a next-PC prediction. It presents {pc, prediction, epoch} to the IF/ID register through a valid/ready output register. It also closes the loop from EX: it detects mispredicts, redirects fetch, flushes the wrong path with an epoch bit, and issues the registered BTB update.

## Interface
- RESET_PC, 32'h8000_0000, first PC fetched after reset
- CNT_BITS, 16, width of saturating mispredict counter
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- btb_pc_query  out  32  PC presented to the BTB (equals pc_q)
- btb_hit  in  1  BTB tag match for btb_pc_query
- btb_target  in  32  BTB predicted target for btb_pc_query
- btb_update_en  out  1  one-cycle BTB write strobe
- btb_pc_update  out  32  PC being written
- btb_target_update  out  32  target being written
- fetch_valid  out  1  output register holds a fetch
- fetch_ready  in  1  downstream accepts the fetch this cycle
- fetch_pc  out  32  PC of the fetch
- fetch_pred_taken  out  1  prediction made for fetch_pc
- fetch_pred_target  out  32  predicted next PC (always the PC that followed)
- fetch_epoch  out  1  epoch tag of the fetch
- ex_valid  in  1  one-cycle pulse: branch/jump resolved in EX
- ex_pc, ex_target  in  32 each  resolved branch PC and taken-target
- ex_taken  in  1  actual direction
- ex_pred_target  in  32  fetch_pred_target carried down the pipe
- ex_epoch  in  1  fetch_epoch carried down the pipe
- mispredict_cnt  out  CNT_BITS  saturating count of accepted mispredicts

## Operation
- Registers: pc_q, output register {fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target, fetch_epoch}, epoch_q, btb_update regs, mispredict_cnt.
- seq = pc_q + 4, mod 2^32 (32'hFFFF_FFFC + 4 = 0).
- pred_taken = btb_hit && (btb_target != seq); pred_next = btb_hit ? btb_target : seq.
- live = ex_valid && (ex_epoch == epoch_q). Resolutions with stale epochs are ignored completely: no redirect, no update, no count.
- actual_next = ex_taken ? ex_target : ex_pc + 4; mispredict = live && (actual_next != ex_pred_target).
- Priority each cycle:
  1. mispredict: pc_q <= actual_next, fetch_valid <= 0, epoch_q <= ~epoch_q; any accept this cycle is dropped.
  2. load (fetch_valid==0 || fetch_ready): output register <= {1, pc_q, pred_taken, pred_next, epoch_q}; pc_q <= pred_next.
  3. else (stall): all hold.
- BTB update on mispredict, registered: btb_update_en <= 1, btb_pc_update <= ex_pc, btb_target_update <= actual_next. Not-taken writes ex_pc+4, which suppresses pred_taken next time; no invalidate is needed.
- mispredict_cnt increments on mispredict and saturates at all-ones.

## Timing
- Reset (async, rst_n low): pc_q = RESET_PC, fetch_valid = 0, fetch_pc = 0, fetch_pred_taken = 0, fetch_pred_target = 0, fetch_epoch = 0, epoch_q = 0, btb_update_en = 0, btb_pc_update = 0, btb_target_update = 0, mispredict_cnt = 0.
- Reset asserted mid-operation clears all state at once; the first fetch after release is RESET_PC.
- btb_pc_query is combinational from pc_q. BTB lookup is combinational, so the prediction is captured in the same cycle.
- First edge after reset release: fetch_valid = 1 with fetch_pc = RESET_PC. Throughput is 1 fetch/cycle while fetch_ready = 1.
- Stall: while fetch_valid && !fetch_ready, all fetch outputs are stable.
- Mispredict at edge N (ex_valid sampled): in cycle N+1, fetch_valid = 0, pc_q = actual_next and btb_update_en = 1 for exactly one cycle. In N+2, fetch_valid = 1 with fetch_pc = actual_next and the new epoch.
- Back-to-back ex_valid: the second resolution carries the old epoch after a mispredict and is therefore ignored.
- A BTB write in N+1 is visible to a query no earlier than N+2.

## Test plan
- Reset release with RESET_PC=0x8000_0000, btb_hit=0, fetch_ready=1 -> fetch_pc sequence 0x80000000, 0x80000004, 0x80000008; fetch_pred_taken=0.
- btb_hit=1, btb_target=0x80000100 at pc 0x80000008 -> next fetch_pc is 0x80000100, with fetch_pred_taken=1 on the 0x80000008 fetch.
- Hold fetch_ready=0 for 3 cycles -> outputs frozen, pc_q unchanged; the stream resumes with no skip or duplicate.
- ex_valid, ex_pc=0x80000010, ex_taken=1, ex_target=0x80000200, ex_pred_target=0x80000014, epoch matching -> next cycle fetch_valid=0, btb_update_en=1 (0x80000010 -> 0x80000200), mispredict_cnt=1; the following cycle fetch_pc=0x80000200 with the epoch flipped.
- Stale-epoch ex_valid with a wrong target -> no redirect, btb_update_en=0, counter unchanged. A not-taken mispredict at 0x80000020 -> update target 0x80000024.
- pc_q=0xFFFFFFFC, no hit -> next fetch_pc=0x00000000. Assert rst_n mid-stall -> all outputs return to their reset values immediately.
